// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the operand-fetch/issue stage: widths, ALU op
// encodings and the hardwired-zero register index.
package ex_operand_stage_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/ex_operand_stage_regfile_2r1w.sv
// Integer register file: two combinational read ports, one clocked write
// port, x0 reads as zero, whole array cleared by the asynchronous reset.
module regfile_2r1w #(
    parameter int XLEN  = ex_operand_stage_pkg::XLEN,
    parameter int NREGS = ex_operand_stage_pkg::NREGS,
    parameter int AW    = ex_operand_stage_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);
    import ex_operand_stage_pkg::*;

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Entry 0 is never written, but gate the read anyway so x0 is zero by construction.
    assign rdata1_o = (raddr1_i == REG_ZERO) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == REG_ZERO) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/ex_operand_stage.sv
// Operand-fetch/issue stage ahead of the ALU: register read with writeback
// bypass, immediate select, and a valid/ready slot that tracks writes while stalled.
module ex_operand_stage #(
    parameter int XLEN  = ex_operand_stage_pkg::XLEN,
    parameter int NREGS = ex_operand_stage_pkg::NREGS,
    parameter int AW    = ex_operand_stage_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            use_imm,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      op_in,
    input  logic [AW-1:0]   rd_addr_in,
    input  logic            rd_we_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [AW-1:0]   rd_addr_out,
    output logic            rd_we_out,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data
);
    import ex_operand_stage_pkg::*;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            rd_we_q, rd_we_d;
    logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    logic            use_imm_q, use_imm_d;

    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic            accept, stall;
    logic            byp1, byp2, refresh1, refresh2;

    regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs1_addr),
        .rdata1_o (rf_rdata1),
        .raddr2_i (rs2_addr),
        .rdata2_o (rf_rdata2),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign stall    = out_valid_q && !out_ready;

    // Bypass for an incoming instruction; refresh for the one held in the slot.
    assign byp1     = wb_en && (wb_addr == rs1_addr) && (rs1_addr != REG_ZERO);
    assign byp2     = wb_en && (wb_addr == rs2_addr) && (rs2_addr != REG_ZERO);
    assign refresh1 = wb_en && (wb_addr == rs1_q) && (rs1_q != REG_ZERO);
    assign refresh2 = wb_en && (wb_addr == rs2_q) && (rs2_q != REG_ZERO) && !use_imm_q;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_addr_d   = rd_addr_q;
        rd_we_d     = rd_we_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        use_imm_d   = use_imm_q;

        if (accept) begin
            out_valid_d = 1'b1;
            alu_a_d     = byp1 ? wb_data : rf_rdata1;
            alu_b_d     = use_imm ? imm : (byp2 ? wb_data : rf_rdata2);
            alu_op_d    = op_in;
            rd_addr_d   = rd_addr_in;
            rd_we_d     = rd_we_in;
            rs1_d       = rs1_addr;
            rs2_d       = rs2_addr;
            use_imm_d   = use_imm;
        end else if (stall) begin
            if (refresh1) alu_a_d = wb_data;
            if (refresh2) alu_b_d = wb_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            use_imm_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_addr_q   <= rd_addr_d;
            rd_we_q     <= rd_we_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            use_imm_q   <= use_imm_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rd_addr_out = rd_addr_q;
    assign rd_we_out   = rd_we_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage with hand-computed expectations.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        use_imm;
    logic [31:0] imm;
    logic [3:0]  op_in;
    logic [4:0]  rd_addr_in;
    logic        rd_we_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd_addr_out;
    logic        rd_we_out;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    ex_operand_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .use_imm     (use_imm),
        .imm         (imm),
        .op_in       (op_in),
        .rd_addr_in  (rd_addr_in),
        .rd_we_in    (rd_we_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .rd_addr_out (rd_addr_out),
        .rd_we_out   (rd_we_out),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] r1, input logic [4:0] r2, input logic ui,
                             input logic [31:0] iv, input logic [3:0] op,
                             input logic [4:0] rd, input logic we);
        in_valid   = 1'b1;
        rs1_addr   = r1;
        rs2_addr   = r2;
        use_imm    = ui;
        imm        = iv;
        op_in      = op;
        rd_addr_in = rd;
        rd_we_in   = we;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        set_wb(1'b1, a, d);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
    endtask

    task automatic check_slot(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [4:0] rd);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".a"}, alu_a, a);
        chk({tag, ".b"}, alu_b, b);
        chk({tag, ".op"}, {28'd0, alu_op}, {28'd0, op});
        chk({tag, ".rd"}, {27'd0, rd_addr_out}, {27'd0, rd});
    endtask

    logic [3:0]  stream_op [4];
    logic [31:0] xval [5];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; rs1_addr = '0; rs2_addr = '0; use_imm = 1'b0; imm = '0;
        op_in = '0; rd_addr_in = '0; rd_we_in = 1'b0; out_ready = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.a", alu_a, 32'd0);
        chk("rst.b", alu_b, 32'd0);
        chk("rst.op", {28'd0, alu_op}, 32'd0);
        chk("rst.rdwe", {26'd0, rd_we_out, rd_addr_out}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Basic issue: x5=7, x6=3, SUB
        wb_write(5'd5, 32'd7);
        wb_write(5'd6, 32'd3);
        set_instr(5'd5, 5'd6, 1'b0, 32'd0, 4'b0110, 5'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        check_slot("basic", 32'd7, 32'd3, 4'b0110, 5'd7);
        chk("basic.we", {31'd0, rd_we_out}, 32'd1);

        // Same-cycle bypass on rs1, then confirm the register file took the write
        set_instr(5'd5, 5'd6, 1'b0, 32'd0, 4'b0010, 5'd8, 1'b0);
        set_wb(1'b1, 5'd5, 32'h100);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        check_slot("bypass", 32'h100, 32'd3, 4'b0010, 5'd8);
        set_instr(5'd5, 5'd0, 1'b0, 32'd0, 4'b0000, 5'd1, 1'b0);
        tick();
        in_valid = 1'b0;
        check_slot("x5_read", 32'h100, 32'd0, 4'b0000, 5'd1);

        // Immediate select: rs2 bypass ignored, rs1=6 bypassed
        set_instr(5'd6, 5'd6, 1'b1, 32'hFFFF_FFFC, 4'b0010, 5'd2, 1'b1);
        set_wb(1'b1, 5'd6, 32'd9);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        in_valid = 1'b0;
        check_slot("imm", 32'd9, 32'hFFFF_FFFC, 4'b0010, 5'd2);
        out_ready = 1'b0;
        wb_write(5'd6, 32'h55);
        check_slot("imm_stall", 32'h55, 32'hFFFF_FFFC, 4'b0010, 5'd2);

        // Backpressure: load P (rs1=5, rs2=6), then stall with Q waiting
        out_ready = 1'b1;
        set_instr(5'd5, 5'd6, 1'b0, 32'd0, 4'b0010, 5'd9, 1'b1);
        tick();
        check_slot("bp_load", 32'h100, 32'h55, 4'b0010, 5'd9);
        out_ready = 1'b0;
        set_instr(5'd6, 5'd5, 1'b0, 32'd0, 4'b0001, 5'd10, 1'b0);
        #1;
        chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_slot("bp_c1", 32'h100, 32'h55, 4'b0010, 5'd9);
        set_wb(1'b1, 5'd5, 32'd42);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        check_slot("bp_c2", 32'd42, 32'h55, 4'b0010, 5'd9);
        chk("bp_c2.in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_slot("bp_c3", 32'd42, 32'h55, 4'b0010, 5'd9);
        out_ready = 1'b1;
        #1;
        chk("bp_rel.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_slot("bp_next", 32'h55, 32'd42, 4'b0001, 5'd10);

        // Streaming: four back-to-back instructions
        xval[0] = 32'd0;
        xval[1] = 32'h11; xval[2] = 32'h22; xval[3] = 32'h33; xval[4] = 32'h44;
        stream_op[0] = 4'b0000; stream_op[1] = 4'b0001;
        stream_op[2] = 4'b0111; stream_op[3] = 4'b1100;
        for (int k = 1; k <= 4; k++) wb_write(k[4:0], xval[k]);
        for (int k = 0; k < 4; k++) begin
            set_instr(5'(k + 1), 5'(4 - k), 1'b0, 32'd0, stream_op[k], 5'(k + 11), 1'b1);
            tick();
            check_slot($sformatf("stream%0d", k), xval[k + 1], xval[4 - k],
                       stream_op[k], 5'(k + 11));
        end

        // Asynchronous reset mid-stream, then x0 write is discarded
        rst = 1'b1;
        #1;
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.a", alu_a, 32'd0);
        chk("arst.b", alu_b, 32'd0);
        chk("arst.op", {28'd0, alu_op}, 32'd0);
        chk("arst.rdwe", {26'd0, rd_we_out, rd_addr_out}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        wb_write(5'd0, 32'hDEAD_BEEF);
        set_instr(5'd0, 5'd5, 1'b0, 32'd0, 4'b0010, 5'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        check_slot("x0", 32'd0, 32'd0, 4'b0010, 5'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
